// File: rtl/serial_subtractor_pkg.sv
// Shared types and elaboration-time constants for the digit-serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Number of RUN cycles needed to walk all digits of an operand.
  function automatic int calc_n(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter must hold 0..N without wrapping inside one operation.
  function automatic int calc_cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_sub_digit.sv
// Combinational DIGIT-bit subtract slice: d = x - y - bi, bo set when that goes negative.
module sub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);

  logic [DIGIT:0] full;

  // One extra bit on the left captures the sign of the slice result, i.e. the borrow.
  assign full = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bi};
  assign d    = full[DIGIT-1:0];
  assign bo   = full[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial unsigned subtractor: diff = a - b - b_in, processed DIGIT bits per clock, LSB first.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             zero
);

  localparam int N     = calc_n(WIDTH, DIGIT);
  localparam int CNT_W = calc_cnt_w(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_subtractor: WIDTH must be >= 1 and a multiple of DIGIT");
  end

  state_e           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] opa_q,    opa_d;
  logic [WIDTH-1:0] opb_q,    opb_d;
  logic             borrow_q, borrow_d;
  logic             ready_q,  ready_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [WIDTH-1:0] diff_q,   diff_d;
  logic             b_out_q,  b_out_d;
  logic             zero_q,   zero_d;

  logic [DIGIT-1:0] dig_d;
  logic             dig_bo;
  logic [WIDTH-1:0] opa_shifted;

  sub_digit #(.DIGIT(DIGIT)) u_sub_digit (
    .x  (opa_q[DIGIT-1:0]),
    .y  (opb_q[DIGIT-1:0]),
    .bi (borrow_q),
    .d  (dig_d),
    .bo (dig_bo)
  );

  // The minuend register doubles as the result accumulator: each new digit enters at the top.
  assign opa_shifted = (opa_q >> DIGIT) | (WIDTH'(dig_d) << (WIDTH - DIGIT));

  always_comb begin
    // NOTE: every _d gets a hold default first so no path through the case can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    borrow_d = borrow_q;
    ready_d  = 1'b1;
    busy_d   = busy_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    b_out_d  = b_out_q;
    zero_d   = zero_q;

    unique case (state_q)
      IDLE: begin
        // ready_q keeps the first edge after reset release from accepting a start.
        if (start && ready_q) begin
          opa_d    = a;
          opb_d    = b;
          borrow_d = b_in;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        opa_d    = opa_shifted;
        opb_d    = opb_q >> DIGIT;
        borrow_d = dig_bo;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          diff_d  = opa_shifted;
          b_out_d = dig_bo;
          zero_d  = (opa_shifted == '0);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      borrow_q <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      b_out_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      borrow_q <= borrow_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      b_out_q  <= b_out_d;
      zero_q   <= zero_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign diff  = diff_q;
  assign b_out = b_out_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: five serial_subtractor configurations against a timer/arithmetic reference model.
module tb_serial_subtractor;

  localparam int NI = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       b_in;

  logic [NI-1:0]      busy_v;
  logic [NI-1:0]      done_v;
  logic [NI-1:0]      bout_v;
  logic [NI-1:0]      zero_v;
  logic [NI-1:0][7:0] diff_v;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Reference result {b_out, zero, diff} straight from the arithmetic definition.
  function automatic logic [9:0] ref_sub(input int w, input int av, input int bv, input int bi);
    int         r;
    logic [7:0] d;
    r = av - bv - bi;
    d = 8'(r & ((1 << w) - 1));
    return {(av < bv + bi), (d == 8'd0), d};
  endfunction

  // Configurations: 0: W8/D1, 1: W8/D4, 2: W4/D1, 3: W4/D2, 4: W4/D4.
  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W    = (g < 2) ? 8 : 4;
    localparam int D    = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 1 : (g == 3) ? 2 : 4;
    localparam int N    = W / D;
    localparam int MASK = (1 << W) - 1;

    logic [W-1:0] diff_o;
    logic         busy_o, done_o, bout_o, zero_o;

    serial_subtractor #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a[W-1:0]),
      .b     (b[W-1:0]),
      .b_in  (b_in),
      .busy  (busy_o),
      .done  (done_o),
      .diff  (diff_o),
      .b_out (bout_o),
      .zero  (zero_o)
    );

    assign busy_v[g] = busy_o;
    assign done_v[g] = done_o;
    assign bout_v[g] = bout_o;
    assign zero_v[g] = zero_o;
    assign diff_v[g] = 8'(diff_o);

    // Model: accept when idle, count N edges, then publish the arithmetic result.
    logic       m_busy = 1'b0, m_done = 1'b0, m_bout = 1'b0, m_zero = 1'b0, m_ready = 1'b0;
    logic [7:0] m_diff = '0, m_a = '0, m_b = '0;
    logic       m_bin = 1'b0;
    int         m_left = 0;
    logic [9:0] m_res;

    assign m_res = ref_sub(W, int'(m_a), int'(m_b), int'(m_bin));

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_busy  <= 1'b0;
        m_done  <= 1'b0;
        m_bout  <= 1'b0;
        m_zero  <= 1'b0;
        m_diff  <= '0;
        m_ready <= 1'b0;
        m_a     <= '0;
        m_b     <= '0;
        m_bin   <= 1'b0;
        m_left  <= 0;
      end else begin
        m_ready <= 1'b1;
        m_done  <= 1'b0;
        if (m_busy) begin
          if (m_left == 1) begin
            m_diff <= m_res[7:0];
            m_zero <= m_res[8];
            m_bout <= m_res[9];
            m_done <= 1'b1;
            m_busy <= 1'b0;
          end
          m_left <= m_left - 1;
        end else if (m_ready && start) begin
          m_a    <= a & 8'(MASK);
          m_b    <= b & 8'(MASK);
          m_bin  <= b_in;
          m_left <= N;
          m_busy <= 1'b1;
        end
      end
    end

    always @(negedge clk) begin
      n_tests++;
      if ({busy_o, done_o, bout_o, zero_o, 8'(diff_o)} !== {m_busy, m_done, m_bout, m_zero, m_diff}) begin
        n_fail++;
        $display("FAIL model_cmp[%0d] t=%0t got busy/done/bout/zero/diff=%b/%b/%b/%b/%h expected %b/%b/%b/%b/%h",
                 g, $time, busy_o, done_o, bout_o, zero_o, diff_o, m_busy, m_done, m_bout, m_zero, m_diff);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy_v != '0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", 32'(busy_v == '0), 32'd1);
  endtask

  task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic bi);
    @(negedge clk);
    a = av; b = bv; b_in = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called on the negedge right after the accepting edge; counts edges until done.
  task automatic wait_done(input int idx, output int lat, output int bcnt);
    lat  = 0;
    bcnt = busy_v[idx] ? 1 : 0;
    while (!done_v[idx] && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy_v[idx]) bcnt++;
    end
    check("done_seen", 32'(done_v[idx]), 32'd1);
  endtask

  task automatic directed(input string name, input int idx, input logic [7:0] av, input logic [7:0] bv,
                          input logic bi, input logic [7:0] ed, input logic eb, input logic ez, input int n);
    int lat, bcnt;
    wait_idle();
    issue(av, bv, bi);
    wait_done(idx, lat, bcnt);
    check({name, "_lat"},  32'(lat),  32'(n));
    check({name, "_busy"}, 32'(bcnt), 32'(n));
    check({name, "_res"},  {22'd0, bout_v[idx], zero_v[idx], diff_v[idx]}, {22'd0, eb, ez, ed});
  endtask

  initial begin
    int lat, bcnt;
    rst_n = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    #1 rst_n = 1'b0;

    check("ref_pin_a", 32'(ref_sub(8, 5, 3, 0)),      {22'd0, 1'b0, 1'b0, 8'h02});
    check("ref_pin_b", 32'(ref_sub(8, 0, 1, 0)),      {22'd0, 1'b1, 1'b0, 8'hFF});
    check("ref_pin_c", 32'(ref_sub(4, 3, 3, 1)),      {22'd0, 1'b1, 1'b0, 8'h0F});

    repeat (2) @(negedge clk);
    check("reset_state", {20'd0, busy_v[0], done_v[0], bout_v[0], zero_v[0], diff_v[0]}, 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    directed("sub_5_3",    0, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 8);
    directed("sub_0_1",    0, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 8);
    directed("sub_zero",   0, 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1, 8);
    directed("sub_ff_ff",  0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 8);
    directed("d4_80_01",   1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 2);

    // Mid-run start and operand change are ignored; start on the done cycle is accepted.
    wait_idle();
    issue(8'h5A, 8'h13, 1'b0);
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'h00; b_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'h77; b = 8'h99;
    wait_done(0, lat, bcnt);
    check("ignore_lat", 32'(lat + 3), 32'd8);
    check("ignore_res", {22'd0, bout_v[0], zero_v[0], diff_v[0]}, {22'd0, 1'b0, 1'b0, 8'h47});
    a = 8'h20; b = 8'h21; b_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(0, lat, bcnt);
    check("b2b_lat", 32'(lat + 1), 32'd9);
    check("b2b_res", {22'd0, bout_v[0], zero_v[0], diff_v[0]}, {22'd0, 1'b1, 1'b0, 8'hFE});

    // Reset in the middle of a run aborts; the edge releasing reset accepts nothing.
    wait_idle();
    issue(8'h33, 8'h11, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_abort", {20'd0, busy_v[0], done_v[0], bout_v[0], zero_v[0], diff_v[0]}, 32'd0);
    repeat (2) @(negedge clk);
    a = 8'h0A; b = 8'h03; b_in = 1'b0; start = 1'b1;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 check("release_edge_ignored", 32'(busy_v[0]), 32'd0);
    @(posedge clk);
    #1 check("start_after_release", 32'(busy_v[0]), 32'd1);
    @(negedge clk);
    start = 1'b0;
    wait_done(0, lat, bcnt);
    check("after_rst_res", {22'd0, bout_v[0], zero_v[0], diff_v[0]}, {22'd0, 1'b0, 1'b0, 8'h07});

    // Exhaustive over the 4-bit operand space; 8-bit instances see random upper bits.
    for (int v = 0; v < 512; v++) begin
      wait_idle();
      @(negedge clk);
      a = {4'($urandom), v[3:0]};
      b = {4'($urandom), v[7:4]};
      b_in = v[8];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end

    // Free-running random traffic with inputs changing every cycle and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom); b_in = 1'($urandom);
      start = ($urandom_range(0, 3) != 0);
      if (!rst_n) begin
        #2 rst_n = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
      end
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
